uart_rx_fifo: RTL

Serial UART receiver with a small first-word-fall-through receive FIFO. It sits in the user project directly downstream of the `mprj_io[5]` pad, which carries serial data from the host or bench UART transmitter. It deserialises 8N1 frames, buffers complete bytes, and presents them to the firmware-facing register logic through a valid/read handshake. Framing and overrun conditions are reported through sticky error flags.

---
 rtl/uart_rx_fifo.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through FIFO with sticky error flags.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 4167,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    input  logic       rd_en_i,
    output logic [7:0] rd_data_o,
    output logic       rd_valid_o,
    output logic       irq_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       parity_err_o,
    input  logic       err_clr_i
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          rx_meta;
    logic          rx_s;

    logic          bit_end;
    logic          stop_sample;
    logic          push;
    logic          frame_set;
    logic          parity_set;

    // Two-flop synchroniser; resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    assign bit_end     = (cnt == CNT_LAST);
    assign stop_sample = (state == STOP) && bit_end;
    assign push        = stop_sample &  rx_s;
    assign frame_set   = stop_sample & ~rx_s;

`ifdef UART_RX_PARITY_EN
    assign parity_set = (state == PAR) && bit_end && ((^shift) ^ rx_s);
`else
    assign parity_set = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                        if (bit_idx == 3'd7) state <= PAR;
`else
                        if (bit_idx == 3'd7) state <= STOP;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PAR: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    // Return to IDLE at mid-stop so a back-to-back start edge is not missed.
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [FIFO_DEPTH];
    logic        full;
    logic        pop;
    logic        push_ok;
    logic        overrun_set;

    assign rd_valid_o  = (wr_ptr != rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop         = rd_en_i & rd_valid_o;
    // When full, a same-cycle pop frees the head slot, which is exactly the slot being written.
    assign push_ok     = push & (~full | pop);
    assign overrun_set = push & full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the output mux below hides stale entries.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= shift;
    end

    assign rd_data_o = rd_valid_o ? mem[rd_ptr[AW-1:0]] : 8'h00;

    logic parity_err_q;

    // NOTE: set is tested before clear so an event coinciding with err_clr_i is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (frame_set)      frame_err_o <= 1'b1;
            else if (err_clr_i) frame_err_o <= 1'b0;

            if (overrun_set)    overrun_o <= 1'b1;
            else if (err_clr_i) overrun_o <= 1'b0;

            if (parity_set)     parity_err_q <= 1'b1;
            else if (err_clr_i) parity_err_q <= 1'b0;
        end
    end

    assign parity_err_o = parity_err_q;
    assign irq_o        = rd_valid_o | frame_err_o | overrun_o;

endmodule
